// File: rtl/sprite_ram_wr_arbiter_if.sv
// Bus bundle for the sprite RAM write arbiter: CPU pixel-write handshake,
// region-fill command, and the registered RAM write port.
interface sprite_ram_wr_arbiter_if #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 3
);
  // CPU single-pixel write channel
  logic                  cpu_wr;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_data;
  logic                  cpu_ready;

  // Region-fill command channel
  logic                  fill_start;
  logic [ADDR_WIDTH-1:0] fill_base;
  logic [ADDR_WIDTH:0]   fill_len;
  logic [DATA_WIDTH-1:0] fill_color;
  logic                  fill_busy;
  logic                  fill_done;

  // RAM write port (read port is owned elsewhere)
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr_w;
  logic [DATA_WIDTH-1:0] ram_din;

  // Requester side: issues CPU writes and fill commands, observes the RAM port
  modport master (
    output cpu_wr, cpu_addr, cpu_data, fill_start, fill_base, fill_len, fill_color,
    input  cpu_ready, fill_busy, fill_done, ram_we, ram_addr_w, ram_din
  );

  // Arbiter side
  modport slave (
    input  cpu_wr, cpu_addr, cpu_data, fill_start, fill_base, fill_len, fill_color,
    output cpu_ready, fill_busy, fill_done, ram_we, ram_addr_w, ram_din
  );
endinterface

// File: rtl/sprite_ram_wr_arbiter.sv
// Sprite RAM write arbiter: merges a one-deep CPU pixel-write buffer with a
// region-fill engine onto a single registered RAM write port. A buffered CPU
// write always wins; the fill simply stalls that cycle.
module sprite_ram_wr_arbiter #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 3
) (
  input  logic                    clk,
  input  logic                    reset_n,
  sprite_ram_wr_arbiter_if.slave  bus
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_FILL = 1'b1
  } state_e;

  state_e                r_state;
  state_e                w_state_next;

  // One-entry CPU holding buffer
  logic                  r_buf_valid;
  logic [ADDR_WIDTH-1:0] r_buf_addr;
  logic [DATA_WIDTH-1:0] r_buf_data;

  // Fill engine context
  logic [ADDR_WIDTH-1:0] r_fill_addr;
  logic [ADDR_WIDTH:0]   r_fill_rem;
  logic [DATA_WIDTH-1:0] r_fill_color;

  // Registered RAM port and completion pulse
  logic                  r_ram_we;
  logic [ADDR_WIDTH-1:0] r_ram_addr;
  logic [DATA_WIDTH-1:0] r_ram_din;
  logic                  r_fill_done;

  logic                  w_cpu_accept;
  logic                  w_fill_accept;
  logic                  w_grant_cpu;
  logic                  w_grant_fill;
  logic                  w_fill_last;

  // A CPU write only enters when the buffer is empty; a full buffer is always
  // granted the same cycle, so it never holds off the fill for more than one slot.
  assign w_cpu_accept  = bus.cpu_wr & ~r_buf_valid;
  assign w_fill_accept = (r_state == S_IDLE) & bus.fill_start;
  assign w_grant_cpu   = r_buf_valid;
  assign w_grant_fill  = (r_state == S_FILL) & ~r_buf_valid;
  assign w_fill_last   = w_grant_fill & (r_fill_rem == {{ADDR_WIDTH{1'b0}}, 1'b1});

  assign bus.cpu_ready  = ~r_buf_valid;
  assign bus.fill_busy  = (r_state == S_FILL);
  assign bus.fill_done  = r_fill_done;
  assign bus.ram_we     = r_ram_we;
  assign bus.ram_addr_w = r_ram_addr;
  assign bus.ram_din    = r_ram_din;

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      // NOTE: sequential state is always updated with <= so every flop samples
      // pre-edge values regardless of block ordering in simulation.
      r_state <= w_state_next;
    end
  end

  // FSM next-state: zero-length fills never leave IDLE; FILL ends on the last granted step
  always_comb begin
    // NOTE: default assigned first so no path leaves w_state_next unassigned
    // (which would infer a latch).
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (bus.fill_start && (bus.fill_len != '0)) w_state_next = S_FILL;
      S_FILL: if (w_fill_last) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // CPU buffer: clears in its grant cycle, loads only when empty
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: these are a handful of control/data flops, not a memory array,
      // so resetting all of them is cheap and keeps outputs deterministic.
      r_buf_valid <= 1'b0;
      r_buf_addr  <= '0;
      r_buf_data  <= '0;
    end else if (w_grant_cpu) begin
      r_buf_valid <= 1'b0;
    end else if (w_cpu_accept) begin
      r_buf_valid <= 1'b1;
      r_buf_addr  <= bus.cpu_addr;
      r_buf_data  <= bus.cpu_data;
    end
  end

  // Fill context: latched on an accepted start, stepped on each granted fill write
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fill_addr  <= '0;
      r_fill_rem   <= '0;
      r_fill_color <= '0;
    end else if (w_fill_accept) begin
      r_fill_addr  <= bus.fill_base;
      r_fill_rem   <= bus.fill_len;
      r_fill_color <= bus.fill_color;
    end else if (w_grant_fill) begin
      // Address wraps naturally at 2**ADDR_WIDTH
      r_fill_addr <= r_fill_addr + 1'b1;
      r_fill_rem  <= r_fill_rem - 1'b1;
    end
  end

  // RAM port and fill_done: the grant decision is registered one cycle out
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_din   <= '0;
      r_fill_done <= 1'b0;
    end else begin
      r_ram_we    <= w_grant_cpu | w_grant_fill;
      r_fill_done <= w_fill_last | (w_fill_accept & (bus.fill_len == '0));
      if (w_grant_cpu) begin
        r_ram_addr <= r_buf_addr;
        r_ram_din  <= r_buf_data;
      end else if (w_grant_fill) begin
        r_ram_addr <= r_fill_addr;
        r_ram_din  <= r_fill_color;
      end
    end
  end

endmodule

// File: tb/tb_sprite_ram_wr_arbiter.sv
// Scoreboard bench for sprite_ram_wr_arbiter: directed stimulus pushes the
// expected RAM write / fill_done events, a negedge monitor pops and compares.
module tb_sprite_ram_wr_arbiter;

  localparam int AW = 11;
  localparam int DW = 3;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          done;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  sprite_ram_wr_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  sprite_ram_wr_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int   n_vectors = 0;
  int   n_miscompares = 0;
  int   we_count = 0;

  task automatic check(input string name, input int unsigned act, input int unsigned expv);
    n_vectors++;
    if (act !== expv) begin
      n_miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic push(input logic we, input int unsigned addr, input int unsigned data, input logic done);
    exp_t e;
    e.we   = we;
    e.addr = AW'(addr);
    e.data = DW'(data);
    e.done = done;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait for the scoreboard to empty, then a few idle cycles to catch strays
  task automatic drain(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      if (q.size() == 0) break;
      tick();
    end
    repeat (4) tick();
    check("drain", q.size(), 0);
  endtask

  task automatic start_fill(input int unsigned base, input int unsigned len, input int unsigned color);
    bus.fill_start = 1'b1;
    bus.fill_base  = AW'(base);
    bus.fill_len   = (AW+1)'(len);
    bus.fill_color = DW'(color);
  endtask

  // Monitor: every visible RAM write or fill_done must match the next expected event
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.ram_we || bus.fill_done) begin
        if (bus.ram_we) we_count++;
        if (q.size() == 0) begin
          check("unexpected_event", {bus.ram_we, bus.fill_done, bus.ram_addr_w}, 0);
        end else begin
          e = q.pop_front();
          check("wr_we", bus.ram_we, e.we);
          if (e.we) begin
            check("wr_addr", bus.ram_addr_w, e.addr);
            check("wr_data", bus.ram_din, e.data);
          end
          check("wr_done", bus.fill_done, e.done);
        end
      end
    end
  end

  initial begin
    int busy_cnt;
    int we_before;

    bus.cpu_wr = 1'b0; bus.cpu_addr = '0; bus.cpu_data = '0;
    bus.fill_start = 1'b0; bus.fill_base = '0; bus.fill_len = '0; bus.fill_color = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_cpu_ready", bus.cpu_ready, 1);
    check("rst_fill_busy", bus.fill_busy, 0);
    check("rst_fill_done", bus.fill_done, 0);
    check("rst_ram_we", bus.ram_we, 0);
    check("rst_ram_addr", bus.ram_addr_w, 0);
    check("rst_ram_din", bus.ram_din, 0);
    reset_n = 1'b1;
    tick();

    // Single CPU write: ready low exactly one cycle, one write pulse
    bus.cpu_wr = 1'b1; bus.cpu_addr = 11'h12A; bus.cpu_data = 3'd5;
    push(1, 'h12A, 5, 0);
    tick();
    bus.cpu_wr = 1'b0;
    check("cpu_ready_low", bus.cpu_ready, 0);
    check("cpu_we_not_yet", bus.ram_we, 0);
    tick();
    check("cpu_ready_back", bus.cpu_ready, 1);
    check("cpu_we_pulse", bus.ram_we, 1);
    tick();
    check("cpu_we_single", bus.ram_we, 0);
    drain(10);

    // Fill with address wrap: 2046,2047,0,1; busy for 4 cycles
    start_fill(2046, 4, 3);
    push(1, 2046, 3, 0); push(1, 2047, 3, 0); push(1, 0, 3, 0); push(1, 1, 3, 1);
    tick();
    bus.fill_start = 1'b0;
    busy_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.fill_busy) busy_cnt++;
      tick();
    end
    check("wrap_busy_cycles", busy_cnt, 4);
    drain(10);

    // Contention plus ignored requests during the fill
    we_before = we_count;
    start_fill(0, 8, 1);
    push(1, 0, 1, 0); push(1, 1, 1, 0); push(1, 2, 1, 0);
    push(1, 'h400, 6, 0);
    for (int a = 3; a < 8; a++) push(1, a, 1, a == 7);
    tick();                                   // fill accepted
    bus.fill_start = 1'b0;
    tick();
    tick();                                   // third fill cycle
    bus.cpu_wr = 1'b1; bus.cpu_addr = 11'h400; bus.cpu_data = 3'd6;
    tick();
    check("cont_cpu_ready_low", bus.cpu_ready, 0);
    // Both of these must be ignored
    bus.cpu_addr = 11'h7FF; bus.cpu_data = 3'd7;
    start_fill(500, 3, 5);
    tick();
    bus.cpu_wr = 1'b0;
    bus.fill_start = 1'b0;
    check("cont_busy_mid", bus.fill_busy, 1);
    drain(20);
    check("cont_we_cycles", we_count - we_before, 9);

    // Zero-length fill: done pulse next cycle, no write, no busy
    we_before = we_count;
    start_fill(5, 0, 2);
    push(0, 0, 0, 1);
    tick();
    bus.fill_start = 1'b0;
    check("len0_busy", bus.fill_busy, 0);
    check("len0_done", bus.fill_done, 1);
    drain(5);
    check("len0_no_we", we_count - we_before, 0);

    // Same-cycle CPU write and fill start in IDLE: CPU goes first
    bus.cpu_wr = 1'b1; bus.cpu_addr = 11'h055; bus.cpu_data = 3'd2;
    start_fill(10, 2, 0);
    push(1, 'h055, 2, 0); push(1, 10, 0, 0); push(1, 11, 0, 1);
    tick();
    bus.cpu_wr = 1'b0;
    bus.fill_start = 1'b0;
    drain(10);

    // Full-RAM fill: every entry once, single fill_done
    we_before = we_count;
    start_fill(1000, 2048, 4);
    for (int i = 0; i < 2048; i++) push(1, (1000 + i) % 2048, 4, i == 2047);
    tick();
    bus.fill_start = 1'b0;
    drain(2200);
    check("full_we_cycles", we_count - we_before, 2048);

    // Reset mid-fill: immediate quiet outputs, no completion afterwards
    start_fill(100, 8, 2);
    push(1, 100, 2, 0); push(1, 101, 2, 0); push(1, 102, 2, 0);
    tick();
    bus.fill_start = 1'b0;
    tick(); tick(); tick();
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("mid_rst_ram_we", bus.ram_we, 0);
    check("mid_rst_fill_busy", bus.fill_busy, 0);
    check("mid_rst_cpu_ready", bus.cpu_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (20) tick();
    check("post_rst_busy", bus.fill_busy, 0);
    drain(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
